// File: rtl/green_seq_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | green_seq_monitor: handoff, serve, conflict, starvation, short-green mon |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module green_seq_monitor #(
  parameter int N_CH      = 4,
  parameter int CNT_W     = 16,
  parameter int MAX_WAIT  = 64,
  parameter int MIN_GREEN = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [N_CH-1:0]            green,
  input  logic [N_CH-1:0]            request,
  input  logic [N_CH*N_CH-1:0]       compat,
  input  logic                       clear,
  output logic                       handoff_valid,
  output logic [$clog2(N_CH)-1:0]    handoff_from,
  output logic [$clog2(N_CH)-1:0]    handoff_to,
  output logic [N_CH*N_CH-1:0]       seen_pairs,
  output logic [N_CH*CNT_W-1:0]      serve_cnt,
  output logic                       conflict,
  output logic [N_CH-1:0]            starve_ch,
  output logic                       short_green,
  output logic [$clog2(N_CH)-1:0]    short_ch
);

  localparam int c_idx_w  = $clog2(N_CH);
  localparam int c_wait_w = $clog2(MAX_WAIT + 1);
  localparam int c_run_w  = $clog2(MIN_GREEN + 1);
  localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(MAX_WAIT);
  localparam logic [c_run_w-1:0]  c_run_min  = c_run_w'(MIN_GREEN);
  localparam logic [CNT_W-1:0]    c_cnt_max  = '1;

  logic [N_CH-1:0]                 prev_green_q, prev_green_d;
  logic                            pending_valid_q, pending_valid_d;
  logic [c_idx_w-1:0]              pending_src_q, pending_src_d;
  logic                            handoff_valid_q, handoff_valid_d;
  logic [c_idx_w-1:0]              handoff_from_q, handoff_from_d;
  logic [c_idx_w-1:0]              handoff_to_q, handoff_to_d;
  logic [N_CH*N_CH-1:0]            seen_pairs_q, seen_pairs_d;
  logic [N_CH-1:0][CNT_W-1:0]      serve_cnt_q, serve_cnt_d;
  logic                            conflict_q, conflict_d;
  logic [N_CH-1:0]                 starve_ch_q, starve_ch_d;
  logic [N_CH-1:0][c_wait_w-1:0]   wait_q, wait_d;
  logic [N_CH-1:0][c_run_w-1:0]    run_q, run_d;
  logic                            short_green_q, short_green_d;
  logic [c_idx_w-1:0]              short_ch_q, short_ch_d;

  logic [N_CH-1:0]    w_rise, w_fall, w_short;
  logic [c_idx_w-1:0] w_rise_idx, w_fall_idx, w_short_idx, w_src;
  logic               w_conflict, w_handoff;

  // Event detection and lowest-index priority encoders.
  always_comb begin
    w_rise      = green & ~prev_green_q;
    w_fall      = ~green & prev_green_q;
    w_rise_idx  = '0;
    w_fall_idx  = '0;
    w_short_idx = '0;
    w_short     = '0;
    w_conflict  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      w_short[i] = w_fall[i] & (run_q[i] < c_run_min);
    end
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_rise[i])  w_rise_idx  = c_idx_w'(i);
      if (w_fall[i])  w_fall_idx  = c_idx_w'(i);
      if (w_short[i]) w_short_idx = c_idx_w'(i);
    end
    for (int i = 0; i < N_CH; i++) begin
      for (int j = 0; j < N_CH; j++) begin
        if (i != j && green[i] && green[j] && !compat[i*N_CH+j]) w_conflict = 1'b1;
      end
    end
    // A fall in the same cycle stands in as the source when nothing is pending.
    w_handoff = (|w_rise) & (pending_valid_q | (|w_fall));
    w_src     = pending_valid_q ? pending_src_q : w_fall_idx;
  end

  always_comb begin
    prev_green_d    = green;
    pending_valid_d = pending_valid_q;
    pending_src_d   = pending_src_q;
    handoff_valid_d = 1'b0;
    handoff_from_d  = handoff_from_q;
    handoff_to_d    = handoff_to_q;
    seen_pairs_d    = seen_pairs_q;
    serve_cnt_d     = serve_cnt_q;
    conflict_d      = conflict_q;
    starve_ch_d     = starve_ch_q;
    wait_d          = wait_q;
    run_d           = run_q;
    short_green_d   = short_green_q;
    short_ch_d      = short_ch_q;

    if (clear) begin
      pending_valid_d = 1'b0;
      pending_src_d   = '0;
      handoff_from_d  = '0;
      handoff_to_d    = '0;
      seen_pairs_d    = '0;
      serve_cnt_d     = '0;
      conflict_d      = 1'b0;
      starve_ch_d     = '0;
      wait_d          = '0;
      run_d           = '0;
      short_green_d   = 1'b0;
      short_ch_d      = '0;
    end else begin
      if (w_handoff) begin
        handoff_valid_d = 1'b1;
        handoff_from_d  = w_src;
        handoff_to_d    = w_rise_idx;
        for (int a = 0; a < N_CH; a++) begin
          for (int b = 0; b < N_CH; b++) begin
            if (w_src == c_idx_w'(a) && w_rise_idx == c_idx_w'(b))
              seen_pairs_d[a*N_CH+b] = 1'b1;
          end
        end
        // Only a fall not consumed as this handoff's source re-arms pending.
        if (pending_valid_q && (|w_fall)) begin
          pending_valid_d = 1'b1;
          pending_src_d   = w_fall_idx;
        end else begin
          pending_valid_d = 1'b0;
        end
      end else if (|w_fall) begin
        pending_valid_d = 1'b1;
        pending_src_d   = w_fall_idx;
      end

      conflict_d = conflict_q | w_conflict;

      for (int i = 0; i < N_CH; i++) begin
        if (w_rise[i] && serve_cnt_q[i] != c_cnt_max)
          serve_cnt_d[i] = serve_cnt_q[i] + 1'b1;

        if (green[i] || !request[i])
          wait_d[i] = '0;
        else if (wait_q[i] != c_wait_max)
          wait_d[i] = wait_q[i] + 1'b1;
        if (wait_d[i] == c_wait_max)
          starve_ch_d[i] = 1'b1;

        if (!green[i])
          run_d[i] = '0;
        else if (run_q[i] != c_run_min)
          run_d[i] = run_q[i] + 1'b1;
      end

      if (!short_green_q && (|w_short)) begin
        short_green_d = 1'b1;
        short_ch_d    = w_short_idx;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_green_q    <= '0;
      pending_valid_q <= 1'b0;
      pending_src_q   <= '0;
      handoff_valid_q <= 1'b0;
      handoff_from_q  <= '0;
      handoff_to_q    <= '0;
      seen_pairs_q    <= '0;
      serve_cnt_q     <= '0;
      conflict_q      <= 1'b0;
      starve_ch_q     <= '0;
      wait_q          <= '0;
      run_q           <= '0;
      short_green_q   <= 1'b0;
      short_ch_q      <= '0;
    end else begin
      prev_green_q    <= prev_green_d;
      pending_valid_q <= pending_valid_d;
      pending_src_q   <= pending_src_d;
      handoff_valid_q <= handoff_valid_d;
      handoff_from_q  <= handoff_from_d;
      handoff_to_q    <= handoff_to_d;
      seen_pairs_q    <= seen_pairs_d;
      serve_cnt_q     <= serve_cnt_d;
      conflict_q      <= conflict_d;
      starve_ch_q     <= starve_ch_d;
      wait_q          <= wait_d;
      run_q           <= run_d;
      short_green_q   <= short_green_d;
      short_ch_q      <= short_ch_d;
    end
  end

  assign handoff_valid = handoff_valid_q;
  assign handoff_from  = handoff_from_q;
  assign handoff_to    = handoff_to_q;
  assign seen_pairs    = seen_pairs_q;
  assign serve_cnt     = serve_cnt_q;
  assign conflict      = conflict_q;
  assign starve_ch     = starve_ch_q;
  assign short_green   = short_green_q;
  assign short_ch      = short_ch_q;

endmodule
`default_nettype wire
